// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback stage and long-latency hazard scoreboard.
//
// Sole driver of the RegisterBank write port. Each cycle it loads at most one
// result into the registered write port: an ALU result has priority,
// otherwise the head of a small FIFO of long-latency (mul/div) results drains.
// Results addressed to x0 are discarded without using the port or the FIFO.
// `busy` marks registers whose long-latency write is still outstanding. The
// issue stage stalls on RAW/WAW hazards against it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid/iss_long        issuing instruction, result from long unit
//   iss_rd/rs1/rs2_addr       its destination and source registers
//   iss_stall                 combinational hazard stall
//   alu_valid/rd_addr/rd_data single-cycle ALU result, no backpressure
//   mul_valid/mul_ready       long-result handshake (ready = FIFO not full)
//   mul_rd_addr/mul_rd_data   long result destination and data
//   write_ena/rd_addr/rd_data registered RegisterBank write port
//   busy                      registered scoreboard, bit r = xr pending
module wb_scoreboard #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_long,
  input  logic [4:0]      iss_rd_addr,
  input  logic [4:0]      iss_rs1_addr,
  input  logic [4:0]      iss_rs2_addr,
  output logic            iss_stall,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd_addr,
  input  logic [XLEN-1:0] alu_rd_data,
  input  logic            mul_valid,
  output logic            mul_ready,
  input  logic [4:0]      mul_rd_addr,
  input  logic [XLEN-1:0] mul_rd_data,
  output logic            write_ena,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic [31:0]     busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       fifo_addr [FIFO_DEPTH];
  logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic        full;
  logic        empty;
  logic        alu_take;
  logic        push;
  logic        pop;
  logic        set_ena;
  logic        from_fifo;
  logic [31:0] busy_next;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign mul_ready = !full;

  // x0 ALU results do not claim the port, so the FIFO may drain instead.
  assign alu_take = alu_valid && (alu_rd_addr != '0);
  assign pop      = !alu_take && !empty;
  // x0 long results complete the handshake but are never stored.
  assign push     = mul_valid && !full && (mul_rd_addr != '0);

  assign iss_stall = iss_valid &&
                     (busy[iss_rs1_addr] | busy[iss_rs2_addr] | busy[iss_rd_addr]);
  assign set_ena   = iss_valid && !iss_stall && iss_long && (iss_rd_addr != '0);

  // Clear on the edge that commits a FIFO-sourced write; a same-edge set wins.
  always_comb begin
    busy_next = busy;
    if (write_ena && from_fifo) busy_next[rd_addr] = 1'b0;
    if (set_ena)                busy_next[iss_rd_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Storage carries no reset; occupancy is governed by count/pointers.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_addr[tail] <= mul_rd_addr;
      fifo_data[tail] <= mul_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      write_ena <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
      from_fifo <= 1'b0;
      busy      <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (alu_take) begin
        write_ena <= 1'b1;
        rd_addr   <= alu_rd_addr;
        rd_data   <= alu_rd_data;
        from_fifo <= 1'b0;
      end else if (pop) begin
        write_ena <= 1'b1;
        rd_addr   <= fifo_addr[head];
        rd_data   <= fifo_data[head];
        from_fifo <= 1'b1;
      end else begin
        write_ena <= 1'b0;
        from_fifo <= 1'b0;
      end

      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Testbench for wb_scoreboard: directed scenarios followed by random traffic,
// checked cycle by cycle against a queue-based reference model and a
// bench-side register bank.
module tb_wb_scoreboard;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_long;
  logic [4:0]      iss_rd_addr, iss_rs1_addr, iss_rs2_addr;
  logic            iss_stall;
  logic            alu_valid;
  logic [4:0]      alu_rd_addr;
  logic [XLEN-1:0] alu_rd_data;
  logic            mul_valid, mul_ready;
  logic [4:0]      mul_rd_addr;
  logic [XLEN-1:0] mul_rd_data;
  logic            write_ena;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [31:0]     busy;

  always #5 clk = ~clk;

  wb_scoreboard #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_long(iss_long),
    .iss_rd_addr(iss_rd_addr), .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_rd_data(alu_rd_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_rd_addr(mul_rd_addr), .mul_rd_data(mul_rd_data),
    .write_ena(write_ena), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending long results as a queue, the write port as
  // plain variables, the scoreboard as a set of register numbers.
  logic [4:0]      mq_addr[$];
  logic [XLEN-1:0] mq_data[$];
  logic            m_we, m_src_fifo;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [31:0]     m_busy;
  logic [XLEN-1:0] m_bank  [32];
  logic [XLEN-1:0] dut_bank[32];

  logic            pre_we;
  logic [4:0]      pre_addr;
  logic [XLEN-1:0] pre_data;
  bit              record;
  logic [4:0]      order[$];
  int              writes_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_stall();
    return iss_valid && (m_busy[iss_rs1_addr] || m_busy[iss_rs2_addr] || m_busy[iss_rd_addr]);
  endfunction

  function automatic logic m_ready();
    return mq_addr.size() < DEPTH;
  endfunction

  task automatic model_update();
    logic stall, ready;
    stall = m_stall();
    ready = m_ready();
    if (rst) begin
      mq_addr.delete(); mq_data.delete();
      m_we = 0; m_addr = 0; m_data = 0; m_src_fifo = 0; m_busy = 0;
    end else begin
      if (m_we) begin
        m_bank[m_addr] = m_data;
        if (m_src_fifo) m_busy[m_addr] = 1'b0;
      end
      if (iss_valid && !stall && iss_long && iss_rd_addr != 0) m_busy[iss_rd_addr] = 1'b1;
      if (alu_valid && alu_rd_addr != 0) begin
        m_we = 1; m_addr = alu_rd_addr; m_data = alu_rd_data; m_src_fifo = 0;
      end else if (mq_addr.size() > 0) begin
        m_we = 1; m_addr = mq_addr.pop_front(); m_data = mq_data.pop_front(); m_src_fifo = 1;
      end else begin
        m_we = 0; m_src_fifo = 0;
      end
      if (mul_valid && ready && mul_rd_addr != 0) begin
        mq_addr.push_back(mul_rd_addr);
        mq_data.push_back(mul_rd_data);
      end
    end
  endtask

  task automatic idle();
    rst = 0; iss_valid = 0; iss_long = 0;
    iss_rd_addr = 0; iss_rs1_addr = 0; iss_rs2_addr = 0;
    alu_valid = 0; alu_rd_addr = 0; alu_rd_data = 0;
    mul_valid = 0; mul_rd_addr = 0; mul_rd_data = 0;
  endtask

  task automatic settle();
    #1;
    chk("mul_ready", mul_ready, m_ready());
    chk("iss_stall", iss_stall, m_stall());
    pre_we = write_ena; pre_addr = rd_addr; pre_data = rd_data;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_update();
    if (pre_we === 1'b1) begin
      dut_bank[pre_addr] = pre_data;
      writes_seen++;
      if (record && pre_addr >= 2 && pre_addr <= 4) order.push_back(pre_addr);
    end
    #1;
    chk("write_ena", write_ena, m_we);
    chk("rd_addr", rd_addr, m_addr);
    chk("rd_data", rd_data, m_data);
    chk("busy", busy, m_busy);
    chk("we_x0", write_ena && (rd_addr == 0), 0);
  endtask

  task automatic cycle();
    settle();
    clk_edge();
  endtask

  initial begin
    int idx;
    bit hs;
    for (int r = 0; r < 32; r++) begin m_bank[r] = 0; dut_bank[r] = 0; end
    m_we = 0; m_addr = 0; m_data = 0; m_src_fifo = 0; m_busy = 0;
    writes_seen = 0; record = 0;

    // 1. Reset held two cycles with an ALU write to x3 presented.
    idle(); rst = 1; alu_valid = 1; alu_rd_addr = 3; alu_rd_data = 32'h33;
    @(posedge clk); model_update(); #1;
    pre_we = write_ena; pre_addr = rd_addr; pre_data = rd_data;
    clk_edge();
    chk("rst_busy", busy, 0);
    chk("rst_bank_x3", dut_bank[3], 0);

    // 2. ALU write to x1.
    idle(); alu_valid = 1; alu_rd_addr = 1; alu_rd_data = 32'h12345678;
    cycle();
    chk("alu_we", write_ena, 1);
    chk("alu_rd_addr", rd_addr, 1);
    idle(); cycle();
    chk("alu_bank_x1", dut_bank[1], 32'h12345678);

    // 3. x0 ALU result while the FIFO holds x5: x5 drains in that slot.
    idle(); alu_valid = 1; alu_rd_addr = 9; alu_rd_data = 32'h99;
    mul_valid = 1; mul_rd_addr = 5; mul_rd_data = 32'hA5A5A5A5;
    cycle();
    idle(); alu_valid = 1; alu_rd_addr = 0; alu_rd_data = 32'hDEADBEEF;
    cycle();
    chk("x0_drain_addr", rd_addr, 5);
    chk("x0_drain_we", write_ena, 1);
    idle(); cycle();
    chk("x0_bank_x0", dut_bank[0], 0);
    chk("x0_bank_x5", dut_bank[5], 32'hA5A5A5A5);

    // 4. RAW on a pending long write to x7.
    idle(); iss_valid = 1; iss_long = 1; iss_rd_addr = 7;
    cycle();
    idle(); iss_valid = 1; iss_rs1_addr = 7; iss_rd_addr = 8;
    mul_valid = 1; mul_rd_addr = 7; mul_rd_data = 32'hCAFEF00D;
    settle(); chk("raw_stall_n", iss_stall, 1); clk_edge();
    mul_valid = 0;
    settle(); chk("raw_stall_n1", iss_stall, 1); clk_edge();
    chk("raw_we", write_ena, 1);
    settle(); chk("raw_stall_during_we", iss_stall, 1); clk_edge();
    settle(); chk("raw_stall_released", iss_stall, 0);
    chk("raw_bank_x7", dut_bank[7], 32'hCAFEF00D);
    clk_edge();

    // 5. Backpressure and ALU priority.
    idle(); idx = 0; record = 1; order.delete();
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 6); alu_rd_addr = 9; alu_rd_data = $urandom;
      mul_valid = (idx < 3); mul_rd_addr = 5'(2 + idx); mul_rd_data = $urandom;
      settle();
      if (c == 3) chk("bp_ready_low", mul_ready, 0);
      hs = mul_valid && mul_ready;
      clk_edge();
      if (hs) idx++;
    end
    record = 0;
    chk("bp_all_sent", idx, 3);
    chk("bp_order_len", order.size(), 3);
    if (order.size() == 3) begin
      chk("bp_order0", order[0], 2);
      chk("bp_order1", order[1], 3);
      chk("bp_order2", order[2], 4);
    end

    // 6. Re-issue of x6 around its commit, then reset with two FIFO entries.
    idle(); iss_valid = 1; iss_long = 1; iss_rd_addr = 6;
    cycle();
    mul_valid = 1; mul_rd_addr = 6; mul_rd_data = 32'h66;
    cycle();
    mul_valid = 0;
    for (int c = 0; c < 4; c++) cycle();
    chk("coll_busy6", busy[6], 1);
    idle(); alu_valid = 1; alu_rd_addr = 9;
    mul_valid = 1; mul_rd_addr = 10; mul_rd_data = 32'hAA;
    cycle();
    mul_rd_addr = 11; mul_rd_data = 32'hBB;
    cycle();
    idle(); rst = 1;
    cycle();
    idle(); writes_seen = 0;
    for (int c = 0; c < 5; c++) cycle();
    chk("rstmid_no_writes", writes_seen, 0);
    chk("rstmid_busy", busy, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst          = ($urandom_range(0, 299) == 0);
      iss_valid    = $urandom_range(0, 1);
      iss_long     = $urandom_range(0, 1);
      iss_rd_addr  = 5'($urandom_range(0, 7));
      iss_rs1_addr = 5'($urandom_range(0, 7));
      iss_rs2_addr = 5'($urandom_range(0, 7));
      alu_valid    = ($urandom_range(0, 9) < 4);
      alu_rd_addr  = 5'($urandom_range(0, 7));
      alu_rd_data  = $urandom;
      mul_valid    = $urandom_range(0, 1);
      mul_rd_addr  = 5'($urandom_range(0, 7));
      mul_rd_data  = $urandom;
      cycle();
    end
    idle();
    for (int c = 0; c < 4; c++) cycle();
    for (int r = 0; r < 32; r++) chk("bank", dut_bank[r], m_bank[r]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
